// File: rtl/module_lfsr_checker_if.sv
// Word/status bundle between a test-pattern source and module_lfsr_checker.
// The source drives the master side; the checker owns the slave side.
interface module_lfsr_checker_if #(
    parameter int NUM_BITS = 32,
    parameter int ERR_W    = 16
);
    logic                i_Valid;
    logic [NUM_BITS-1:0] i_Data;
    logic                i_Clear;
    logic                o_Locked;
    logic                o_Error;
    logic [ERR_W-1:0]    o_Err_Count;
    logic [31:0]         o_Bit_Err_Count;

    modport master (
        output i_Valid, i_Data, i_Clear,
        input  o_Locked, o_Error, o_Err_Count, o_Bit_Err_Count
    );

    modport slave (
        input  i_Valid, i_Data, i_Clear,
        output o_Locked, o_Error, o_Err_Count, o_Bit_Err_Count
    );
endinterface

// File: rtl/module_lfsr_checker.sv
// Self-synchronising checker for the XNOR Fibonacci LFSR word stream.
// Define LFSR_CHK_BITERR_EN to build the mismatched-bit counter; otherwise it reads 0.
module module_lfsr_checker #(
    parameter int NUM_BITS = 32,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    module_lfsr_checker_if.slave  bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} state_e;

    // Tap k of the generator's polynomial maps to bit k-1 of the mask.
    function automatic logic [31:0] tap_mask(input int n);
        case (n)
            3:  return 32'h0000_0006;
            4:  return 32'h0000_000C;
            5:  return 32'h0000_0014;
            6:  return 32'h0000_0030;
            7:  return 32'h0000_0060;
            8:  return 32'h0000_00B8;
            9:  return 32'h0000_0110;
            10: return 32'h0000_0240;
            11: return 32'h0000_0500;
            12: return 32'h0000_0829;
            13: return 32'h0000_100D;
            14: return 32'h0000_2015;
            15: return 32'h0000_6000;
            16: return 32'h0000_D008;
            17: return 32'h0001_2000;
            18: return 32'h0002_0400;
            19: return 32'h0004_0023;
            20: return 32'h0009_0000;
            21: return 32'h0014_0000;
            22: return 32'h0030_0000;
            23: return 32'h0042_0000;
            24: return 32'h00E1_0000;
            25: return 32'h0120_0000;
            26: return 32'h0200_0023;
            27: return 32'h0400_0013;
            28: return 32'h0900_0000;
            29: return 32'h1400_0000;
            30: return 32'h2000_0029;
            31: return 32'h4800_0000;
            32: return 32'h8020_0003;
            default: return 32'h0;
        endcase
    endfunction

    localparam logic [31:0] TAPS = tap_mask(NUM_BITS);

    // An XNOR chain over n taps is the XOR parity, inverted when n is even.
    function automatic logic [NUM_BITS-1:0] predict(input logic [NUM_BITS-1:0] w);
        logic [31:0] w32;
        logic        fb;
        w32 = 32'(w);
        fb  = (TAPS == 32'h0) ? 1'b0 : ((^(w32 & TAPS)) ^ (~^TAPS));
        return {w[NUM_BITS-2:0], fb};
    endfunction

    state_e              state_q, state_d;
    logic [NUM_BITS-1:0] ref_q, ref_d;
    logic [MW-1:0]       match_q, match_d;
    logic [LW-1:0]       miss_q, miss_d;
    logic                err_q, err_d;
    logic [ERR_W-1:0]    cnt_q, cnt_d;

    logic [NUM_BITS-1:0] pred;
    logic                match, all_ones;
    logic [MW-1:0]       match_inc;
    logic [LW-1:0]       miss_inc;

    assign pred      = predict(ref_q);
    assign all_ones  = &bus.i_Data;
    assign match     = (bus.i_Data == pred);
    assign match_inc = match_q + MW'(1);
    assign miss_inc  = miss_q + LW'(1);

    always_ff @(posedge i_Clk or negedge i_Rst) begin : state_reg
        if (!i_Rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        if (bus.i_Valid) begin
            case (state_q)
                S_IDLE:  if (!all_ones) state_d = S_ACQ;
                S_ACQ: begin
                    if (all_ones)                                 state_d = S_IDLE;
                    else if (match && match_inc == MW'(LOCK_CNT)) state_d = S_LOCK;
                end
                S_LOCK:  if (!match && miss_inc == LW'(LOSS_CNT)) state_d = S_ACQ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin : outputs_next
        ref_d   = ref_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (bus.i_Valid) begin
            case (state_q)
                S_IDLE: begin
                    if (!all_ones) begin
                        ref_d   = bus.i_Data;
                        match_d = '0;
                    end
                end
                S_ACQ: begin
                    ref_d = bus.i_Data;
                    if (match && !all_ones) begin
                        match_d = match_inc;
                        miss_d  = '0;
                    end else begin
                        match_d = '0;
                    end
                end
                S_LOCK: begin
                    // Free-running: the local copy advances regardless of the received word.
                    ref_d = pred;
                    if (match) begin
                        miss_d = '0;
                    end else begin
                        err_d  = 1'b1;
                        miss_d = miss_inc;
                        if (cnt_q != '1) cnt_d = cnt_q + ERR_W'(1);
                        if (miss_inc == LW'(LOSS_CNT)) begin
                            ref_d   = bus.i_Data;
                            match_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (bus.i_Clear) cnt_d = '0;
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin : data_reg
        if (!i_Rst) begin
            ref_q   <= '0;
            match_q <= '0;
            miss_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ref_q   <= ref_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_Locked    = (state_q == S_LOCK);
    assign bus.o_Error     = err_q;
    assign bus.o_Err_Count = cnt_q;

`ifdef LFSR_CHK_BITERR_EN
    logic [NUM_BITS-1:0] diff;
    logic [5:0]          pop;
    logic [32:0]         bsum;
    logic [31:0]         bits_q, bits_d;

    assign diff = bus.i_Data ^ pred;

    always_comb begin : bit_err_next
        pop = '0;
        for (int i = 0; i < NUM_BITS; i++) pop = pop + 6'(diff[i]);
        bsum   = {1'b0, bits_q} + 33'(pop);
        bits_d = bits_q;
        if (bus.i_Valid && state_q == S_LOCK && !match)
            bits_d = bsum[32] ? '1 : bsum[31:0];
        if (bus.i_Clear) bits_d = '0;
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin : bit_err_reg
        if (!i_Rst) bits_q <= '0;
        else        bits_q <= bits_d;
    end

    assign bus.o_Bit_Err_Count = bits_q;
`else
    assign bus.o_Bit_Err_Count = 32'h0;
`endif
endmodule

// File: tb/tb_module_lfsr_checker.sv
// Directed bench for module_lfsr_checker: lock, error counting, clear, loss/relock,
// all-ones lockup, valid gaps, counter saturation (ERR_W=4) and async reset.
module tb_module_lfsr_checker;
    localparam logic [31:0] SEED = 32'hda1e_bebe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    module_lfsr_checker_if #(.NUM_BITS(32), .ERR_W(16)) ia ();
    module_lfsr_checker_if #(.NUM_BITS(32), .ERR_W(4))  ib ();

    module_lfsr_checker #(.NUM_BITS(32), .LOCK_CNT(8), .LOSS_CNT(4), .ERR_W(16)) dut_a (
        .i_Clk(clk), .i_Rst(rst_n), .bus(ia));
    module_lfsr_checker #(.NUM_BITS(32), .LOCK_CNT(8), .LOSS_CNT(4), .ERR_W(4)) dut_b (
        .i_Clk(clk), .i_Rst(rst_n), .bus(ib));

    int errors = 0;
    int checks = 0;
    logic [31:0] ga, gb;

    typedef struct {
        logic        v;
        logic [31:0] mask;
        logic        clr;
        logic        lk;
        logic        er;
        logic [15:0] cnt;
        logic [31:0] bits;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [31:0] gen(input logic [31:0] w);
        return {w[30:0], ~(w[31] ^ w[21] ^ w[1] ^ w[0])};
    endfunction

    function automatic logic [31:0] bexp(input logic [31:0] b);
`ifdef LFSR_CHK_BITERR_EN
        return b;
`else
        return 32'h0 & b;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic v, input logic [31:0] d, input logic c);
        ia.i_Valid = v; ia.i_Data = d; ia.i_Clear = c;
        tick();
    endtask

    task automatic feed_a(input logic [31:0] mask, input logic c);
        ga = gen(ga);
        drv_a(1'b1, ga ^ mask, c);
    endtask

    task automatic drv_b(input logic v, input logic [31:0] d, input logic c);
        ib.i_Valid = v; ib.i_Data = d; ib.i_Clear = c;
        tick();
    endtask

    task automatic feed_b(input logic [31:0] mask);
        gb = gen(gb);
        drv_b(1'b1, gb ^ mask, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ia.i_Valid = 1'b0; ia.i_Clear = 1'b0; ia.i_Data = '0;
        ib.i_Valid = 1'b0; ib.i_Clear = 1'b0; ib.i_Data = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic seen;
        tbl[0] = '{1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 16'd1, 32'd1};
        tbl[1] = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 16'd1, 32'd1};
        tbl[2] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 16'd1, 32'd1};
        tbl[3] = '{1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 16'd2, 32'd2};
        tbl[4] = '{1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 16'd0, 32'd0};
        tbl[5] = '{1'b1, 32'h0000_00F0, 1'b0, 1'b1, 1'b1, 16'd1, 32'd4};
        tbl[6] = '{1'b1, 32'h0000_0003, 1'b1, 1'b1, 1'b1, 16'd0, 32'd0};
        tbl[7] = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 16'd0, 32'd0};

        ia.i_Valid = 1'b0; ia.i_Clear = 1'b0; ia.i_Data = '0;
        ib.i_Valid = 1'b0; ib.i_Clear = 1'b0; ib.i_Data = '0;
        repeat (2) tick();
        check("rst_locked", 32'(ia.o_Locked), 32'd0);
        check("rst_error",  32'(ia.o_Error), 32'd0);
        check("rst_cnt",    32'(ia.o_Err_Count), 32'd0);
        check("rst_bits",   ia.o_Bit_Err_Count, 32'd0);
        rst_n = 1'b1;
        tick();

        // Clean stream: lock after the 9th word, then 1000 words error-free.
        ga = SEED;
        drv_a(1'b1, ga, 1'b0);
        seen = 1'b0;
        for (int k = 2; k <= 1000; k++) begin
            feed_a(32'h0, 1'b0);
            seen = seen | ia.o_Error;
            if (k == 8) check("lock_pre_9th", 32'(ia.o_Locked), 32'd0);
            if (k == 9) check("lock_at_9th",  32'(ia.o_Locked), 32'd1);
        end
        check("clean_locked", 32'(ia.o_Locked), 32'd1);
        check("clean_cnt",    32'(ia.o_Err_Count), 32'd0);
        check("clean_no_err", 32'(seen), 32'd0);

        // Locked error table: single flips, idle cycle, clear alone and with an error.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].v) feed_a(tbl[i].mask, tbl[i].clr);
            else          drv_a(1'b0, ga, tbl[i].clr);
            check($sformatf("tbl%0d_locked", i), 32'(ia.o_Locked), 32'(tbl[i].lk));
            check($sformatf("tbl%0d_error", i),  32'(ia.o_Error), 32'(tbl[i].er));
            check($sformatf("tbl%0d_cnt", i),    32'(ia.o_Err_Count), 32'(tbl[i].cnt));
            check($sformatf("tbl%0d_bits", i),   ia.o_Bit_Err_Count, bexp(tbl[i].bits));
        end

        // Four consecutive bad words drop lock; clean stream relocks after 1 resync + 8 matches.
        for (int k = 1; k <= 4; k++) begin
            feed_a(32'h1, 1'b0);
            check($sformatf("loss%0d_error", k),  32'(ia.o_Error), 32'd1);
            check($sformatf("loss%0d_cnt", k),    32'(ia.o_Err_Count), 32'(k));
            check($sformatf("loss%0d_locked", k), 32'(ia.o_Locked), (k < 4) ? 32'd1 : 32'd0);
        end
        check("loss_bits", ia.o_Bit_Err_Count, bexp(32'd4));
        seen = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            feed_a(32'h0, 1'b0);
            seen = seen | ia.o_Error;
            if (k == 8) check("relock_pre", 32'(ia.o_Locked), 32'd0);
        end
        check("relock",        32'(ia.o_Locked), 32'd1);
        check("relock_cnt",    32'(ia.o_Err_Count), 32'd4);
        check("relock_no_err", 32'(seen), 32'd0);

        // Constant all-ones never acquires; a real stream afterwards still locks.
        do_reset();
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drv_a(1'b1, 32'hFFFF_FFFF, 1'b0);
            seen = seen | ia.o_Locked | ia.o_Error | (ia.o_Err_Count != 16'd0);
        end
        check("ones_quiet", 32'(seen), 32'd0);
        ga = SEED;
        drv_a(1'b1, ga, 1'b0);
        for (int k = 2; k <= 9; k++) feed_a(32'h0, 1'b0);
        check("ones_then_lock", 32'(ia.o_Locked), 32'd1);

        // Valid every third cycle.
        do_reset();
        ga = SEED;
        seen = 1'b0;
        drv_a(1'b1, ga, 1'b0);
        repeat (2) drv_a(1'b0, ga, 1'b0);
        for (int k = 2; k <= 9; k++) begin
            feed_a(32'h0, 1'b0);
            seen = seen | ia.o_Error;
            if (k == 8) check("gap_lock_pre", 32'(ia.o_Locked), 32'd0);
            if (k == 9) check("gap_lock",     32'(ia.o_Locked), 32'd1);
            repeat (2) begin
                drv_a(1'b0, ga, 1'b0);
                seen = seen | ia.o_Error;
            end
            if (k == 8) check("gap_lock_hold", 32'(ia.o_Locked), 32'd0);
        end
        check("gap_no_err", 32'(seen), 32'd0);
        feed_a(32'h1, 1'b0);
        check("gap_err_cnt", 32'(ia.o_Err_Count), 32'd1);
        feed_a(32'h0, 1'b0);
        feed_a(32'h4, 1'b1);
        check("clr_vs_err_pulse", 32'(ia.o_Error), 32'd1);
        check("clr_vs_err_cnt",   32'(ia.o_Err_Count), 32'd0);
        check("clr_vs_err_lock",  32'(ia.o_Locked), 32'd1);
        ia.i_Valid = 1'b0; ia.i_Clear = 1'b0;

        // ERR_W=4 saturation with alternating bad/good words.
        gb = SEED;
        drv_b(1'b1, gb, 1'b0);
        for (int k = 2; k <= 9; k++) feed_b(32'h0);
        check("b_lock", 32'(ib.o_Locked), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            feed_b(32'h1);
            check($sformatf("b_sat%0d", k), 32'(ib.o_Err_Count), (k < 15) ? 32'(k) : 32'd15);
            feed_b(32'h0);
        end
        check("b_sat_locked", 32'(ib.o_Locked), 32'd1);

        // Async reset between edges while an error pulse is showing.
        feed_b(32'h1);
        check("b_pre_rst_err", 32'(ib.o_Error), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_b_locked", 32'(ib.o_Locked), 32'd0);
        check("arst_b_error",  32'(ib.o_Error), 32'd0);
        check("arst_b_cnt",    32'(ib.o_Err_Count), 32'd0);
        check("arst_a_locked", 32'(ia.o_Locked), 32'd0);
        check("arst_a_bits",   ia.o_Bit_Err_Count, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
